// File: rtl/timer_sched.sv
// Bus-master sequencer driving one timer through its slave port: programs periodic
// mode, acknowledges N expirations as tick pulses, then stops the timer.
module timer_sched #(
  parameter int unsigned MIN_PERIOD = 4,
  parameter int unsigned BUS_TO     = 16,
  parameter int unsigned REP_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             cancel,
  input  logic [31:0]      period,
  input  logic [REP_W-1:0] reps,
  output logic             busy,
  output logic             tick,
  output logic [REP_W-1:0] tick_cnt,
  output logic             done,
  output logic             err,
  output logic             t_cs_,
  output logic             t_as_,
  output logic             t_rw,
  output logic [1:0]       t_addr,
  output logic [31:0]      t_wr_data,
  input  logic             t_rdy_,
  input  logic             t_irq
);

  localparam int unsigned TO_W = $clog2(BUS_TO + 1);

  typedef enum logic [3:0] {
    IDLE, W_STOP, W_EXPR, W_CNT, W_CLR, W_RUN, WAIT, W_ACK, W_END, DONE
  } state_t;

  state_t           state;
  logic [31:0]      period_q;
  logic [REP_W-1:0] reps_q;
  logic             cancel_q;
  logic [TO_W-1:0]  to_cnt;

  logic             cancel_any;
  logic [REP_W-1:0] tick_next;
  logic [1:0]       acc_addr;
  logic [31:0]      acc_data;
  state_t           acc_next;

  assign cancel_any = cancel | cancel_q;
  // Free-running mode (reps == 0) holds the count at all-ones instead of wrapping.
  assign tick_next  = (reps_q == '0 && tick_cnt == '1) ? tick_cnt : tick_cnt + REP_W'(1);

  always_comb begin
    acc_addr = 2'd0;
    acc_data = '0;
    acc_next = IDLE;
    case (state)
      W_STOP: acc_next = W_EXPR;
      W_EXPR: begin acc_addr = 2'd2; acc_data = period_q; acc_next = W_CNT; end
      W_CNT:  begin acc_addr = 2'd3; acc_next = W_CLR; end
      W_CLR:  begin acc_addr = 2'd1; acc_next = W_RUN; end
      W_RUN:  begin acc_data = 32'h3; acc_next = WAIT; end
      W_ACK:  begin
        acc_addr = 2'd1;
        acc_next = (reps_q != '0 && tick_next == reps_q) ? W_END : WAIT;
      end
      W_END:  acc_next = DONE;
      default: acc_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      period_q  <= '0;
      reps_q    <= '0;
      cancel_q  <= 1'b0;
      to_cnt    <= '0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      tick_cnt  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      t_cs_     <= 1'b1;
      t_as_     <= 1'b1;
      t_rw      <= 1'b1;
      t_addr    <= '0;
      t_wr_data <= '0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
      if (state != IDLE && cancel) cancel_q <= 1'b1;
      case (state)
        IDLE: begin
          cancel_q <= 1'b0;
          if (req) begin
            if (period < MIN_PERIOD) begin
              err <= 1'b1;
            end else begin
              period_q <= period;
              reps_q   <= reps;
              tick_cnt <= '0;
              busy     <= 1'b1;
              state    <= W_STOP;
            end
          end
        end
        WAIT: begin
          if (cancel_any) state <= W_END;
          else if (t_irq) state <= W_ACK;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          // Each access state spends its first cycle with the bus released (the
          // inter-access gap), then strobes and holds until rdy_ or timeout.
          if (t_cs_) begin
            t_cs_     <= 1'b0;
            t_as_     <= 1'b0;
            t_rw      <= 1'b0;
            t_addr    <= acc_addr;
            t_wr_data <= acc_data;
            to_cnt    <= '0;
          end else if (!t_rdy_) begin
            t_cs_ <= 1'b1;
            t_as_ <= 1'b1;
            t_rw  <= 1'b1;
            if (state == W_ACK) begin
              tick     <= 1'b1;
              tick_cnt <= tick_next;
            end
            if (state == W_END) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (cancel_any) begin
              state <= W_END;
            end else begin
              state <= acc_next;
            end
          end else if (to_cnt == TO_W'(BUS_TO - 1)) begin
            t_cs_ <= 1'b1;
            t_as_ <= 1'b1;
            t_rw  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_sched.sv
// Bench for timer_sched: behavioural timer slave plus a run-level model of the
// expected bus write sequence, tick count/spacing and handshake pulses.
module tb_timer_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] period = '0;
  logic [15:0] reps = '0;
  logic        busy, tick, done, err;
  logic [15:0] tick_cnt;
  logic        t_cs_, t_as_, t_rw, t_rdy_, t_irq;
  logic [1:0]  t_addr;
  logic [31:0] t_wr_data;

  int vectors = 0;
  int miscompares = 0;

  timer_sched #(.MIN_PERIOD(4), .BUS_TO(16), .REP_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .cancel(cancel), .period(period), .reps(reps),
    .busy(busy), .tick(tick), .tick_cnt(tick_cnt), .done(done), .err(err),
    .t_cs_(t_cs_), .t_as_(t_as_), .t_rw(t_rw), .t_addr(t_addr), .t_wr_data(t_wr_data),
    .t_rdy_(t_rdy_), .t_irq(t_irq)
  );

  always #5 clk = ~clk;

  // Timer slave: periodic counter 0..EXPR, irq on wrap, expiry beats an INTR clear.
  logic [1:0]  tm_ctrl = '0;
  logic [31:0] tm_expr = '0;
  logic [31:0] tm_cnt = '0;
  logic        tm_irq = 1'b0;
  logic        tm_rdy_ = 1'b1;
  logic        tm_hang = 1'b0;
  assign t_rdy_ = tm_rdy_;
  assign t_irq  = tm_irq;

  always @(posedge clk) begin : tmr
    logic ex;
    ex = (tm_ctrl == 2'b11) && (tm_cnt == tm_expr);
    if (tm_ctrl == 2'b11) tm_cnt <= ex ? 32'd0 : tm_cnt + 32'd1;
    if (ex) tm_irq <= 1'b1;
    if (!t_cs_ && !t_as_ && tm_rdy_ && !tm_hang) begin
      tm_rdy_ <= 1'b0;
      if (!t_rw) begin
        case (t_addr)
          2'd0: tm_ctrl <= t_wr_data[1:0];
          2'd1: if (!ex) tm_irq <= 1'b0;
          2'd2: tm_expr <= t_wr_data;
          default: tm_cnt <= t_wr_data;
        endcase
      end
    end else if (t_cs_) begin
      tm_rdy_ <= 1'b1;
    end
  end

  // Monitor: completed accesses {rw,addr,data}, tick times, pulse bookkeeping.
  logic [34:0] wr_q[$];
  int          tk_q[$];
  int          cyc = 0, n_done = 0, n_err = 0, n_cs_low = 0;
  int          done_cyc = 0, busy_fall = 0;
  logic [15:0] done_tcnt = '0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!t_cs_ && !t_as_ && !tm_rdy_) wr_q.push_back({t_rw, t_addr, t_wr_data});
    if (tick) tk_q.push_back(cyc);
    if (done) begin n_done++; done_cyc = cyc; done_tcnt = tick_cnt; end
    if (err) n_err++;
    if (!t_cs_) n_cs_low++;
    if (busy_prev && !busy) busy_fall = cyc;
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/t_cs_"}, t_cs_, 1);
    check({tag, "/t_as_"}, t_as_, 1);
    check({tag, "/t_rw"}, t_rw, 1);
    check({tag, "/t_addr"}, t_addr, 0);
    check({tag, "/t_wr_data"}, t_wr_data, 0);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/tick"}, tick, 0);
    check({tag, "/done"}, done, 0);
    check({tag, "/err"}, err, 0);
    check({tag, "/tick_cnt"}, tick_cnt, 0);
  endtask

  // One accepted run. cx_ticks>0: cancel in the cycle the cx_ticks-th tick shows
  // (controller is then waiting); cx_expr: cancel while the EXPR write is on the bus.
  task automatic run(input string nm, input logic [31:0] p, input logic [15:0] r,
                     input int cx_ticks, input bit cx_expr);
    logic [34:0] exp_q[$];
    int w0, k0, d0, e0, n, seen, nw, nk;
    bit fin, cx_sent;
    w0 = wr_q.size(); k0 = tk_q.size(); d0 = n_done; e0 = n_err;
    seen = 0; fin = 0; cx_sent = 0;
    period = p; reps = r; req = 1'b1;
    @(negedge clk);
    req = 1'b0; period = $urandom; reps = 16'($urandom);
    check({nm, "/busy_start"}, busy, 1);
    check({nm, "/tick_cnt_start"}, tick_cnt, 0);
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      cancel = 1'b0;
      if (tick) seen++;
      if (done || err) fin = 1;
      else if (!cx_sent && ((cx_ticks > 0 && tick && seen == cx_ticks) ||
                            (cx_expr && !t_cs_ && t_addr == 2'd2))) begin
        cancel = 1'b1; cx_sent = 1;
      end
    end
    cancel = 1'b0;
    check({nm, "/ended_in_budget"}, fin, 1);
    repeat (4) @(negedge clk);

    n = cx_expr ? 0 : (cx_ticks > 0 ? cx_ticks : int'(r));
    exp_q.push_back({1'b0, 2'd0, 32'd0});
    exp_q.push_back({1'b0, 2'd2, p});
    if (!cx_expr) begin
      exp_q.push_back({1'b0, 2'd3, 32'd0});
      exp_q.push_back({1'b0, 2'd1, 32'd0});
      exp_q.push_back({1'b0, 2'd0, 32'd3});
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 2'd1, 32'd0});
    end
    exp_q.push_back({1'b0, 2'd0, 32'd0});

    nw = wr_q.size() - w0;
    nk = tk_q.size() - k0;
    check({nm, "/n_writes"}, nw, exp_q.size());
    for (int i = 0; i < nw && i < exp_q.size(); i++)
      check($sformatf("%s/write%0d", nm, i), wr_q[w0 + i], exp_q[i]);
    check({nm, "/n_ticks"}, nk, n);
    for (int i = 1; i < nk; i++)
      check($sformatf("%s/tick_gap%0d", nm, i), tk_q[k0 + i] - tk_q[k0 + i - 1], p + 1);
    check({nm, "/n_done"}, n_done - d0, 1);
    check({nm, "/n_err"}, n_err - e0, 0);
    check({nm, "/tick_cnt_at_done"}, done_tcnt, n);
    check({nm, "/busy_fall"}, busy_fall, done_cyc + 1);
    check({nm, "/bus_idle"}, t_cs_, 1);
  endtask

  task automatic reject(input string nm, input logic [31:0] p);
    int c0, e0;
    c0 = n_cs_low; e0 = n_err;
    period = p; reps = 16'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check({nm, "/err_pulse"}, err, 1);
    check({nm, "/busy"}, busy, 0);
    check({nm, "/t_cs_"}, t_cs_, 1);
    repeat (6) @(negedge clk);
    check({nm, "/no_bus"}, n_cs_low - c0, 0);
    check({nm, "/one_err"}, n_err - e0, 1);
    check({nm, "/busy_after"}, busy, 0);
  endtask

  initial begin
    int c0, d0, e0, w0, seen;
    bit fin;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    run("basic", 32'd9, 16'd3, 0, 0);
    reject("reject2", 32'd2);
    reject("reject3", 32'd3);
    run("min_period", 32'd4, 16'd3, 0, 0);
    run("cancel_wait", 32'd20, 16'd0, 5, 0);
    repeat (30) @(negedge clk);
    check("cancel_wait/no_late_tick", tk_q.size() > 0 ? (cyc - tk_q[tk_q.size() - 1]) > 30 : 0, 1);

    // Slave never answers: bus held for the timeout, then err and release.
    tm_hang = 1'b1;
    c0 = n_cs_low; d0 = n_done; e0 = n_err; w0 = wr_q.size(); fin = 0;
    period = 32'd9; reps = 16'd3; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (err) fin = 1;
    end
    check("timeout/err_seen", fin, 1);
    repeat (3) @(negedge clk);
    check("timeout/cs_low_cycles", n_cs_low - c0, 16);
    check("timeout/no_done", n_done - d0, 0);
    check("timeout/one_err", n_err - e0, 1);
    check("timeout/bus_released", t_cs_, 1);
    check("timeout/busy", busy, 0);
    check("timeout/no_writes", wr_q.size() - w0, 0);
    tm_hang = 1'b0;
    @(negedge clk);

    run("cancel_expr", 32'd12, 16'd4, 0, 1);

    // Reset while waiting for an expiry, then a clean restart.
    period = 32'd9; reps = 16'd5; req = 1'b1; seen = 0;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(negedge clk);
      if (tick) seen++;
    end
    check("rst_wait/first_tick", seen, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_wait");
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check("rst_wait/stays_idle", busy, 0);
    run("restart", 32'd9, 16'd2, 0, 0);

    for (int it = 0; it < 8; it++) begin
      logic [31:0] p;
      logic [15:0] r;
      int mode, k;
      p = $urandom_range(24, 4);
      mode = $urandom_range(2, 0);
      r = 16'($urandom_range(5, 1));
      k = 0;
      if (mode == 1) k = $urandom_range(int'(r), 1);
      if (mode == 2) begin r = 16'd0; k = $urandom_range(4, 1); end
      run($sformatf("rand%0d", it), p, r, k, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Bus-master sequencer that owns one `timer` instance through the timer's slave bus port.
- On a single request it programs the timer for periodic mode, runs it for N expirations, acknowledges each IRQ, then stops the timer.
- A client (DMA pacer, sampling engine) sees only a request/tick/done handshake, not the timer register map.
- Sits between the client and the timer's `cs_`/`as_`/`rw`/`addr`/`wr_data`/`rdy_` and `irq` signals; the bus decoder is not involved.

Parameters:
- MIN_PERIOD, 4, smallest accepted `period` value; smaller requests are rejected.
- BUS_TO, 16, cycles to wait for `t_rdy_` on one access before aborting with `err`.
- REP_W, 16, width of the repetition count.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- req  in  1  start pulse; sampled only in IDLE
- cancel  in  1  stop request; sampled in any non-IDLE state
- period  in  32  value written to the timer EXPR register; expiry interval is period+1 cycles
- reps  in  REP_W  number of expirations; 0 means run until `cancel`
- busy  out  1  high in every non-IDLE state
- tick  out  1  one-cycle pulse per acknowledged expiry
- tick_cnt  out  REP_W  expirations acknowledged in the current run
- done  out  1  one-cycle pulse when a run ends normally or by cancel
- err  out  1  one-cycle pulse on rejected request or bus timeout
- t_cs_  out  1  timer chip select, active-low
- t_as_  out  1  timer address strobe, active-low
- t_rw  out  1  1=READ, 0=WRITE; this block only writes
- t_addr  out  2  0=CTRL, 1=INTR, 2=EXPR, 3=COUNTER
- t_wr_data  out  32  timer write data
- t_rdy_  in  1  timer ready, active-low
- t_irq  in  1  timer interrupt

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: t_cs_=1, t_as_=1, t_rw=1, t_addr=0, t_wr_data=0, busy=0, tick=0, done=0, err=0, tick_cnt=0; state=IDLE.
- Reset mid-run drops the bus immediately. The timer keeps its state until it is itself reset.
- Bus access (one write):
  - Drive t_cs_=0, t_as_=0, t_rw=0, t_addr and t_wr_data, and hold them until t_rdy_=0 is sampled.
  - The timer returns rdy_ one cycle after the strobe, so a nominal access is 2 cycles.
  - After rdy_ is seen, deassert cs_/as_ for at least one cycle before the next access.
  - A per-access counter runs to BUS_TO. On expiry: deassert the bus, pulse err, go to IDLE, no done.
- CTRL encoding: bit0=start, bit1=mode, with mode 1=periodic.
- Capture: period and reps are captured on req.
- Rejection: if period < MIN_PERIOD, pulse err the next cycle, perform no bus access, and stay IDLE.
- FSM:
  - IDLE: on req, clear tick_cnt, go to W_STOP.
  - W_STOP: write CTRL=0.
  - W_EXPR: write EXPR=period.
  - W_CNT: write COUNTER=0.
  - W_CLR: write INTR=0.
  - W_RUN: write CTRL=32'h3.
  - WAIT: wait for t_irq=1.
  - W_ACK: write INTR=0, then pulse tick and increment tick_cnt in the cycle after rdy_.
  - After W_ACK: if reps!=0 and tick_cnt (post-increment) == reps, go to W_END; else go to WAIT.
  - W_END: write CTRL=0.
  - DONE: pulse done, go to IDLE.
- Cancel:
  - Latched as a sticky flag.
  - When the current access completes, or immediately in WAIT, go to W_END.
  - An expiry pending at cancel is not acknowledged and not ticked.
- IRQ vs ack race: the timer gives expiry priority over an INTR write. If t_irq is still 1 on entering WAIT, it is treated as a new expiry, so no ticks are lost while period+1 exceeds the ack latency. MIN_PERIOD guarantees this.
- tick_cnt saturates at all-ones when reps=0.
- req while busy is ignored.

Test Plan:
- period=9, reps=3, req → bus writes in order CTRL=0, EXPR=9, COUNTER=0, INTR=0, CTRL=3; three tick pulses spaced 10 cycles apart; CTRL=0 written; done pulse; tick_cnt=3; busy falls in the cycle after done.
- period=2 (< MIN_PERIOD), req → err pulse one cycle later, t_cs_ stays 1, busy stays 0.
- period=20, reps=0, cancel asserted after 5 ticks, mid-WAIT → CTRL=0 written, done pulse, tick_cnt=5, no 6th tick.
- t_rdy_ tied high, req with period=9 → bus held 16 cycles, then err pulse, bus released, no done.
- cancel asserted during the W_EXPR access → that access completes, then W_END (CTRL=0), done, tick_cnt=0.
- reset asserted while in WAIT with reps=5 → next cycle all outputs at reset values; a new req starts cleanly with tick_cnt=0.
